// File: rtl/m_stage_lsu.sv
// rtl/m_stage_lsu.sv - M-stage load/store unit: data-memory handshake, lane steering, load extension.
// Optional watchdog abort with bus_err when LSU_TIMEOUT_EN is defined.
module m_stage_lsu #(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  M_mem_write,
   input  logic [1:0]            M_result_src,
   input  logic [1:0]            M_type_control,
   input  logic                  M_sign_ext_flag,
   input  logic [DATA_WIDTH-1:0] M_alu_result,
   input  logic [DATA_WIDTH-1:0] M_write_data,
   input  logic                  ext_stall,
   output logic                  dmem_req_valid,
   input  logic                  dmem_req_ready,
   output logic [DATA_WIDTH-1:0] dmem_addr,
   output logic                  dmem_we,
   output logic [3:0]            dmem_be,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   input  logic                  dmem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] dmem_rdata,
   output logic [DATA_WIDTH-1:0] M_read_data,
   output logic                  mem_stall,
`ifdef LSU_TIMEOUT_EN
   output logic                  bus_err,
`endif
   output logic                  misalign_err
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]            be_q, be_d;
   logic                  we_q, we_d, sext_q, sext_d;
   logic [1:0]            size_q, size_d, lane_q, lane_d;

   logic                  is_store, is_load, is_access, misaligned, aligned_access;
   logic [3:0]            be_new;
   logic [DATA_WIDTH-1:0] wdata_new, load_ext;
   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = 16;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bus_err_q, bus_err_d;
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = TIMEOUT_CYCLES;
`endif

   always_comb begin
      is_store       = M_mem_write;
      is_load        = (M_result_src == 2'b01) && !M_mem_write;
      is_access      = is_store || is_load;
      // Type 2'b11 falls into the word case via bit 1.
      misaligned     = ((M_type_control == 2'b01) && M_alu_result[0]) ||
                       (M_type_control[1] && (M_alu_result[1:0] != 2'b00));
      aligned_access = is_access && !misaligned;
   end

   always_comb begin
      case (M_type_control)
         2'b00: begin
            be_new    = 4'b0001 << M_alu_result[1:0];
            wdata_new = {4{M_write_data[7:0]}};
         end
         2'b01: begin
            be_new    = 4'b0011 << {M_alu_result[1], 1'b0};
            wdata_new = {2{M_write_data[15:0]}};
         end
         default: begin
            be_new    = 4'hF;
            wdata_new = M_write_data;
         end
      endcase
   end

   always_comb begin
      byte_sel = dmem_rdata[8*lane_q +: 8];
      half_sel = dmem_rdata[16*lane_q[1] +: 16];
      case (size_q)
         2'b00:   load_ext = {{(DATA_WIDTH-8){sext_q & byte_sel[7]}}, byte_sel};
         2'b01:   load_ext = {{(DATA_WIDTH-16){sext_q & half_sel[15]}}, half_sel};
         default: load_ext = dmem_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      be_d    = be_q;
      we_d    = we_q;
      sext_d  = sext_q;
      size_d  = size_q;
      lane_d  = lane_q;
      case (state_q)
         S_IDLE: if (aligned_access) begin
            state_d = S_REQ;
            addr_d  = {M_alu_result[DATA_WIDTH-1:2], 2'b00};
            we_d    = is_store;
            be_d    = be_new;
            wdata_d = is_store ? wdata_new : '0;
            sext_d  = M_sign_ext_flag;
            size_d  = M_type_control;
            lane_d  = M_alu_result[1:0];
         end
         S_REQ:  if (dmem_req_ready) state_d = we_q ? S_DONE : S_WAIT;
         S_WAIT: if (dmem_rsp_valid) begin
            rdata_d = load_ext;
            state_d = S_DONE;
         end
         default: if (!ext_stall) state_d = S_IDLE;
      endcase
`ifdef LSU_TIMEOUT_EN
      bus_err_d = 1'b0;
      cnt_d     = '0;
      // Counter runs only while parked in REQ/WAIT; any state entry clears it.
      if (((state_q == S_REQ) || (state_q == S_WAIT)) && (state_d == state_q)) begin
         if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
            state_d   = S_DONE;
            rdata_d   = '0;
            bus_err_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         be_q    <= '0;
         we_q    <= 1'b0;
         sext_q  <= 1'b0;
         size_q  <= '0;
         lane_q  <= '0;
`ifdef LSU_TIMEOUT_EN
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         be_q    <= be_d;
         we_q    <= we_d;
         sext_q  <= sext_d;
         size_q  <= size_d;
         lane_q  <= lane_d;
`ifdef LSU_TIMEOUT_EN
         cnt_q     <= cnt_d;
         bus_err_q <= bus_err_d;
`endif
      end
   end

   assign dmem_req_valid = (state_q == S_REQ);
   assign dmem_addr      = addr_q;
   assign dmem_we        = (state_q != S_IDLE) && we_q;
   assign dmem_be        = (state_q != S_IDLE) ? be_q : 4'h0;
   assign dmem_wdata     = wdata_q;
   assign M_read_data    = rdata_q;
   assign mem_stall      = ((state_q == S_IDLE) && aligned_access) ||
                           (state_q == S_REQ) || (state_q == S_WAIT);
   assign misalign_err   = (state_q == S_IDLE) && is_access && misaligned;
`ifdef LSU_TIMEOUT_EN
   assign bus_err        = bus_err_q;
`endif

endmodule

// File: tb/tb_m_stage_lsu.sv
// tb/tb_m_stage_lsu.sv - directed scoreboard bench for m_stage_lsu (timeout case under LSU_TIMEOUT_EN).
module tb_m_stage_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        M_mem_write, M_sign_ext_flag, ext_stall;
   logic [1:0]  M_result_src, M_type_control;
   logic [31:0] M_alu_result, M_write_data;
   logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, M_read_data;
   logic [3:0]  dmem_be;
   logic        mem_stall, misalign_err;
`ifdef LSU_TIMEOUT_EN
   logic        bus_err;
`endif

   int vectors     = 0;
   int miscompares = 0;
   logic [31:0] sb[$];

   m_stage_lsu #(
      .DATA_WIDTH(32),
`ifdef LSU_TIMEOUT_EN
      .TIMEOUT_CYCLES(4)
`else
      .TIMEOUT_CYCLES(255)
`endif
   ) dut (
      .clk(clk), .rst(rst),
      .M_mem_write(M_mem_write), .M_result_src(M_result_src),
      .M_type_control(M_type_control), .M_sign_ext_flag(M_sign_ext_flag),
      .M_alu_result(M_alu_result), .M_write_data(M_write_data),
      .ext_stall(ext_stall),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid),
      .dmem_rdata(dmem_rdata), .M_read_data(M_read_data),
      .mem_stall(mem_stall),
`ifdef LSU_TIMEOUT_EN
      .bus_err(bus_err),
`endif
      .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic we, input logic [1:0] src, input logic [1:0] typ,
                            input logic sext, input logic [31:0] addr, input logic [31:0] wd);
      M_mem_write     = we;
      M_result_src    = src;
      M_type_control  = typ;
      M_sign_ext_flag = sext;
      M_alu_result    = addr;
      M_write_data    = wd;
   endtask

   task automatic idle_step(input string tag);
      set_instr(1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
      next_cycle();
      check({tag, "_idle_be"}, dmem_be, 32'h0);
      check({tag, "_idle_we"}, dmem_we, 32'h0);
      check({tag, "_idle_stall"}, mem_stall, 32'h0);
   endtask

   // Plays the memory side for one access and checks the request fields and stall length.
   task automatic run_access(input string tag, input logic [31:0] e_addr, input logic [3:0] e_be,
                             input logic e_we, input logic [31:0] e_wdata, input int rdy_dly,
                             input int rsp_dly, input logic [31:0] rsp_word, input int e_stalls);
      int stalls = 0;
      int vwait  = 0;
      int rwait  = 0;
      bit accepted = 0;
      bit done     = 0;
      logic [31:0] exp;
      for (int c = 0; c < 50 && !done; c++) begin
         dmem_req_ready = 1'b0;
         dmem_rsp_valid = 1'b0;
         dmem_rdata     = rsp_word;
         #1;
         if (c > 0 && !mem_stall) begin
            done = 1;
            check({tag, "_stall_cycles"}, stalls, e_stalls);
            if (!e_we) begin
               if (sb.size() == 0) check({tag, "_sb_empty"}, 32'h0, 32'h1);
               else begin
                  exp = sb.pop_front();
                  check({tag, "_rdata"}, M_read_data, exp);
               end
            end
         end else begin
            if (mem_stall) stalls++;
            if (dmem_req_valid) begin
               check({tag, "_addr"}, dmem_addr, e_addr);
               check({tag, "_be"}, dmem_be, e_be);
               check({tag, "_we"}, dmem_we, e_we);
               if (e_we) check({tag, "_wdata"}, dmem_wdata, e_wdata);
               if (vwait >= rdy_dly) begin
                  dmem_req_ready = 1'b1;
                  accepted       = 1;
               end
               vwait++;
            end else if (accepted && !e_we) begin
               if (rwait >= rsp_dly) dmem_rsp_valid = 1'b1;
               rwait++;
            end
            next_cycle();
         end
      end
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      if (!done) check({tag, "_no_done"}, 32'h0, 32'h1);
   endtask

   initial begin
      int  to_pulses;
      int  to_stalls;
      bit  to_fell;
      rst = 1'b0;
      ext_stall = 1'b0;
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      dmem_rdata = 32'h0;
      set_instr(1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_valid", dmem_req_valid, 32'h0);
      check("rst_be", dmem_be, 32'h0);
      check("rst_addr", dmem_addr, 32'h0);
      check("rst_rdata", M_read_data, 32'h0);
      check("rst_stall", mem_stall, 32'h0);
      rst = 1'b1;
      next_cycle();

      set_instr(1'b0, 2'b01, 2'b10, 1'b0, 32'h100, 32'h0);
      sb.push_back(32'hDEADBEEF);
      run_access("lw", 32'h100, 4'hF, 1'b0, 32'h0, 0, 0, 32'hDEADBEEF, 3);
      idle_step("lw");

      set_instr(1'b0, 2'b01, 2'b00, 1'b1, 32'h103, 32'h0);
      sb.push_back(32'hFFFFFF80);
      run_access("lb", 32'h100, 4'b1000, 1'b0, 32'h0, 0, 0, 32'h80112233, 3);
      set_instr(1'b0, 2'b01, 2'b00, 1'b0, 32'h103, 32'h0);
      sb.push_back(32'h00000080);
      next_cycle();
      run_access("lbu", 32'h100, 4'b1000, 1'b0, 32'h0, 0, 0, 32'h80112233, 3);
      idle_step("lbu");

      set_instr(1'b1, 2'b00, 2'b01, 1'b0, 32'h202, 32'h0000ABCD);
      run_access("sh", 32'h200, 4'b1100, 1'b1, 32'hABCDABCD, 3, 0, 32'h0, 5);
      idle_step("sh");

      ext_stall = 1'b1;
      set_instr(1'b1, 2'b00, 2'b00, 1'b0, 32'h001, 32'h12345678);
      run_access("sb", 32'h000, 4'b0010, 1'b1, 32'h78787878, 0, 0, 32'h0, 2);
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         check("done_hold_stall", mem_stall, 32'h0);
         check("done_hold_req", dmem_req_valid, 32'h0);
      end
      ext_stall = 1'b0;
      idle_step("sb");

      set_instr(1'b0, 2'b01, 2'b01, 1'b1, 32'h002, 32'h0);
      sb.push_back(32'hFFFF8001);
      run_access("lh", 32'h000, 4'b1100, 1'b0, 32'h0, 0, 0, 32'h80017FFF, 3);
      idle_step("lh");
      set_instr(1'b0, 2'b01, 2'b01, 1'b0, 32'h000, 32'h0);
      sb.push_back(32'h00007FFF);
      run_access("lhu", 32'h000, 4'b0011, 1'b0, 32'h0, 0, 0, 32'h80017FFF, 3);
      idle_step("lhu");

      set_instr(1'b0, 2'b01, 2'b11, 1'b0, 32'h010, 32'h0);
      sb.push_back(32'h13579BDF);
      run_access("lw11_slow", 32'h010, 4'hF, 1'b0, 32'h0, 0, 2, 32'h13579BDF, 5);
      idle_step("lw11");

      set_instr(1'b0, 2'b01, 2'b10, 1'b0, 32'h101, 32'h0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("mis_lw_err", misalign_err, 32'h1);
         check("mis_lw_stall", mem_stall, 32'h0);
         check("mis_lw_req", dmem_req_valid, 32'h0);
         check("mis_lw_rdata", M_read_data, 32'h13579BDF);
         next_cycle();
      end
      set_instr(1'b1, 2'b00, 2'b01, 1'b0, 32'h201, 32'h5555);
      #1;
      check("mis_sh_err", misalign_err, 32'h1);
      check("mis_sh_stall", mem_stall, 32'h0);
      idle_step("mis");
      check("mis_cleared", misalign_err, 32'h0);

      set_instr(1'b1, 2'b00, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D);
      run_access("sw", 32'h300, 4'hF, 1'b1, 32'hCAFEF00D, 0, 0, 32'h0, 2);
      idle_step("sw");

`ifdef LSU_TIMEOUT_EN
      to_pulses = 0;
      to_stalls = 0;
      to_fell   = 0;
      set_instr(1'b0, 2'b01, 2'b10, 1'b0, 32'h040, 32'h0);
      for (int c = 0; c < 30 && !to_fell; c++) begin
         dmem_req_ready = 1'b0;
         #1;
         dmem_req_ready = dmem_req_valid;
         if (bus_err) to_pulses++;
         if (c > 0 && !mem_stall) to_fell = 1;
         else begin
            if (mem_stall) to_stalls++;
            next_cycle();
         end
      end
      dmem_req_ready = 1'b0;
      check("to_stall_fell", to_fell, 32'h1);
      check("to_rdata_zero", M_read_data, 32'h0);
      set_instr(1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         if (bus_err) to_pulses++;
      end
      check("to_bus_err_pulses", to_pulses, 32'h1);
`endif

      set_instr(1'b0, 2'b01, 2'b10, 1'b0, 32'h080, 32'h0);
      dmem_req_ready = 1'b1;
      next_cycle();
      next_cycle();
      dmem_req_ready = 1'b0;
      check("rstw_in_wait", mem_stall, 32'h1);
      rst = 1'b0;
      #1;
      check("rstw_req", dmem_req_valid, 32'h0);
      check("rstw_addr", dmem_addr, 32'h0);
      check("rstw_be", dmem_be, 32'h0);
      set_instr(1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
      next_cycle();
      rst = 1'b1;
      dmem_rsp_valid = 1'b1;
      dmem_rdata = 32'hFFFFFFFF;
      next_cycle();
      dmem_rsp_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("rstw_rdata", M_read_data, 32'h0);
         check("rstw_stall", mem_stall, 32'h0);
         check("rstw_we", dmem_we, 32'h0);
         check("rstw_wdata", dmem_wdata, 32'h0);
         next_cycle();
      end
      check("sb_drained", sb.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
